// File: rtl/sum_operand_tx.sv
`default_nettype none
// ============================================================================
// Module      : sum_operand_tx
// Description : Captures N operands in one load and streams them LANES per
//               beat over valid/ready, then reports the golden sum.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_operand_tx #(
    parameter int N               = 50,
    parameter int W               = 5,
    parameter int LANES           = 9,
    localparam int SW             = W + $clog2(N),
    localparam int BEATS          = (N + LANES - 1) / LANES,
    localparam int BW             = $clog2(BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_ops,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic [LANES-1:0]     out_mask,
    output logic [BW-1:0]        out_beat,
    output logic                 out_last,
    output logic                 sum_valid,
    output logic [SW-1:0]        sum_ref
);

    localparam int PW = BEATS * LANES * W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N*W-1:0]     ops_q, ops_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [SW-1:0]      acc_q, acc_d;
    logic [SW-1:0]      sum_ref_q, sum_ref_d;

    logic [PW-1:0]      ops_pad;
    logic [LANES*W-1:0] beat_data;
    logic [LANES-1:0]   beat_mask;
    logic [SW-1:0]      beat_sum;
    logic               is_last;
    int                 beat_sel;

    // Zero-pad the buffer to a whole number of beats so every beat is one slice.
    generate
        if (PW > N * W) begin : g_pad
            assign ops_pad = {{(PW - N * W){1'b0}}, ops_q};
        end else begin : g_nopad
            assign ops_pad = ops_q;
        end
    endgenerate

    always_comb begin
        beat_sel  = (int'(beat_q) < BEATS) ? int'(beat_q) : 0;
        beat_data = ops_pad[beat_sel * LANES * W +: LANES * W];
        beat_mask = '0;
        beat_sum  = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_mask[l] = (beat_sel * LANES + l) < N;
            if (beat_mask[l]) begin
                beat_sum = beat_sum + SW'(beat_data[l * W +: W]);
            end
        end
        is_last = (beat_q == BW'(BEATS - 1));
    end

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        beat_d    = beat_q;
        acc_d     = acc_q;
        sum_ref_d = sum_ref_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_mask  = '0;
        out_last  = 1'b0;
        sum_valid = 1'b0;
        sum_ref   = sum_ref_q;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ops_d     = in_ops;
                    beat_d    = '0;
                    acc_d     = '0;
                    sum_ref_d = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = beat_data;
                out_mask  = beat_mask;
                out_last  = is_last;
                if (out_ready) begin
                    acc_d  = acc_q + beat_sum;
                    beat_d = beat_q + BW'(1);
                    if (is_last) begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                // Final sum is visible in the pulse cycle and held afterwards.
                sum_valid = 1'b1;
                sum_ref   = acc_q;
                sum_ref_d = acc_q;
                beat_d    = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_beat = beat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ops_q     <= '0;
            beat_q    <= '0;
            acc_q     <= '0;
            sum_ref_q <= '0;
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            beat_q    <= beat_d;
            acc_q     <= acc_d;
            sum_ref_q <= sum_ref_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_operand_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_operand_tx
// Description : Randomized self-checking bench for sum_operand_tx against an
//               array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_operand_tx;

    localparam int N     = 50;
    localparam int W     = 5;
    localparam int LANES = 9;
    localparam int BEATS = 6;
    localparam int SW    = 11;
    localparam int BW    = 3;
    localparam int N8    = 8;
    localparam int L8    = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N*W-1:0]       in_ops = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [LANES*W-1:0]   out_data;
    logic [LANES-1:0]     out_mask;
    logic [BW-1:0]        out_beat;
    logic                 out_last;
    logic                 sum_valid;
    logic [SW-1:0]        sum_ref;

    logic                 d8_in_valid = 1'b0;
    logic                 d8_in_ready;
    logic [N8*W-1:0]      d8_in_ops = '0;
    logic                 d8_out_valid;
    logic                 d8_out_ready = 1'b0;
    logic [L8*W-1:0]      d8_out_data;
    logic [L8-1:0]        d8_out_mask;
    logic [0:0]           d8_out_beat;
    logic                 d8_out_last;
    logic                 d8_sum_valid;
    logic [7:0]           d8_sum_ref;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int op_val[N];

    sum_operand_tx dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_beat(out_beat), .out_last(out_last),
        .sum_valid(sum_valid), .sum_ref(sum_ref)
    );

    sum_operand_tx #(.N(N8), .W(W), .LANES(L8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_ops(d8_in_ops),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready), .out_data(d8_out_data),
        .out_mask(d8_out_mask), .out_beat(d8_out_beat), .out_last(d8_out_last),
        .sum_valid(d8_sum_valid), .sum_ref(d8_sum_ref)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pack_ops();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(op_val[i]);
        return v;
    endfunction

    function automatic int model_sum();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += op_val[i];
        return s;
    endfunction

    function automatic logic [LANES*W-1:0] model_data(input int b);
        logic [LANES*W-1:0] d;
        d = '0;
        for (int l = 0; l < LANES; l++)
            if (b * LANES + l < N) d[l*W +: W] = W'(op_val[b * LANES + l]);
        return d;
    endfunction

    function automatic logic [LANES-1:0] model_mask(input int b);
        logic [LANES-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++) m[l] = (b * LANES + l < N);
        return m;
    endfunction

    // Loads op_val, streams all beats with optional stalls / in_valid noise, checks the report.
    task automatic xfer(input string name, input int stall_pct, input bit pulse);
        int eb, guard, esum;
        bit go;
        esum  = model_sum();
        eb    = 0;
        guard = 0;
        in_ops   = pack_ops();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (eb < BEATS && guard < 400) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== model_data(eb) || out_mask !== model_mask(eb) ||
                out_beat !== BW'(eb) || out_last !== (eb == BEATS - 1)) begin
                errors++;
                $display("FAIL %s beat %0d: got valid=%b data=%h mask=%h beat=%0d last=%b, want valid=1 data=%h mask=%h beat=%0d last=%b",
                         name, eb, out_valid, out_data, out_mask, out_beat, out_last,
                         model_data(eb), model_mask(eb), eb, (eb == BEATS - 1));
            end
            if (pulse) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in_ready during send: got %b want 0", name, in_ready);
                end
            end
            go = ($urandom_range(99) >= stall_pct);
            out_ready = go;
            if (pulse) begin
                in_valid = ($urandom_range(1) == 1) && !(go && eb == BEATS - 1);
                for (int i = 0; i < N; i++) in_ops[i*W +: W] = W'($urandom);
            end
            tick();
            if (go) eb++;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (eb < BEATS) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, eb, BEATS);
        end
        checks++;
        if (sum_valid !== 1'b1 || sum_ref !== SW'(esum) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s report: got sum_valid=%b sum_ref=%0d out_valid=%b, want 1 %0d 0",
                     name, sum_valid, sum_ref, out_valid, esum);
        end
        tick();
        checks++;
        if (sum_valid !== 1'b0 || in_ready !== 1'b1 || sum_ref !== SW'(esum)) begin
            errors++;
            $display("FAIL %s after report: got sum_valid=%b in_ready=%b sum_ref=%0d, want 0 1 %0d",
                     name, sum_valid, in_ready, sum_ref, esum);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset handshake: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== '0 || out_mask !== '0 || out_beat !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset beat outputs: got data=%h mask=%h beat=%0d last=%b want zeros",
                     out_data, out_mask, out_beat, out_last);
        end
        checks++;
        if (sum_valid !== 1'b0 || sum_ref !== '0) begin
            errors++;
            $display("FAIL reset sum: got sum_valid=%b sum_ref=%0d want 0 0", sum_valid, sum_ref);
        end
        checks++;
        if (d8_in_ready !== 1'b1 || d8_out_valid !== 1'b0 || d8_sum_ref !== '0) begin
            errors++;
            $display("FAIL reset dut8: got in_ready=%b out_valid=%b sum_ref=%0d want 1 0 0",
                     d8_in_ready, d8_out_valid, d8_sum_ref);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < N; i++) op_val[i] = 1;
        xfer("all_ones", 0, 1'b0);
    endtask

    task automatic test_all_max();
        for (int i = 0; i < N; i++) op_val[i] = 31;
        xfer("all_max", 0, 1'b0);
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) op_val[i] = i % 32;
        xfer("ramp", 0, 1'b0);
    endtask

    task automatic test_stalls();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) op_val[i] = int'($urandom_range(31));
            xfer("stall", 50, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        for (int i = 0; i < N; i++) op_val[i] = int'($urandom_range(31));
        in_ops    = pack_ops();
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_beat !== BW'(4)) begin
            errors++;
            $display("FAIL reset_mid pre: got out_valid=%b beat=%0d want 1 4", out_valid, out_beat);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_ref !== '0 || sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got out_valid=%b in_ready=%b sum_ref=%0d sum_valid=%b want 0 1 0 0",
                     out_valid, in_ready, sum_ref, sum_valid);
        end
        bad = 1'b0;
        repeat (8) begin
            tick();
            if (sum_valid !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid quiet: got activity after abandon, want none");
        end
        for (int i = 0; i < N; i++) op_val[i] = int'($urandom_range(31));
        xfer("after_reset", 25, 1'b0);
    endtask

    task automatic test_single_beat();
        int esum;
        esum = 0;
        for (int i = 0; i < N8; i++) begin
            d8_in_ops[i*W +: W] = W'(i);
            esum += i;
        end
        d8_out_ready = 1'b1;
        d8_in_valid  = 1'b1;
        tick();
        d8_in_valid  = 1'b0;
        checks++;
        if (d8_out_valid !== 1'b1 || d8_out_data !== d8_in_ops || d8_out_mask !== 8'hFF) begin
            errors++;
            $display("FAIL single_beat data: got valid=%b data=%h mask=%h want 1 %h ff",
                     d8_out_valid, d8_out_data, d8_out_mask, d8_in_ops);
        end
        checks++;
        if (d8_out_last !== 1'b1 || d8_out_beat !== 1'b0) begin
            errors++;
            $display("FAIL single_beat last: got last=%b beat=%0d want 1 0", d8_out_last, d8_out_beat);
        end
        tick();
        checks++;
        if (d8_sum_valid !== 1'b1 || d8_sum_ref !== 8'(esum) || d8_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_beat sum: got sum_valid=%b sum_ref=%0d want 1 %0d",
                     d8_sum_valid, d8_sum_ref, esum);
        end
        tick();
        d8_out_ready = 1'b0;
        checks++;
        if (d8_sum_valid !== 1'b0 || d8_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_beat idle: got sum_valid=%b in_ready=%b want 0 1", d8_sum_valid, d8_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] vec_b;
        int sa, sb, p0, p1, s0, s1, guard;
        bit cap_b;
        for (int i = 0; i < N; i++) op_val[i] = int'($urandom_range(31));
        sa = model_sum();
        in_ops = pack_ops();
        for (int i = 0; i < N; i++) op_val[i] = int'($urandom_range(31));
        sb = model_sum();
        vec_b = pack_ops();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_ops = vec_b;
        p0 = -1; p1 = -1; s0 = -1; s1 = -1; guard = 0; cap_b = 1'b0;
        while (p1 < 0 && guard < 60) begin
            if (sum_valid === 1'b1) begin
                if (p0 < 0) begin
                    p0 = cyc; s0 = int'(sum_ref);
                end else begin
                    p1 = cyc; s1 = int'(sum_ref);
                end
            end
            if (cap_b) begin
                in_valid = 1'b0;
            end else if (p0 >= 0 && in_ready === 1'b1) begin
                cap_b = 1'b1;
                checks++;
                if (cyc != p0 + 1) begin
                    errors++;
                    $display("FAIL b2b capture cycle: got %0d want %0d", cyc, p0 + 1);
                end
            end
            if (p1 < 0) tick();
            guard++;
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (p0 < 0 || p1 < 0 || p1 - p0 != 8) begin
            errors++;
            $display("FAIL b2b spacing: got pulses at %0d and %0d want 8 apart", p0, p1);
        end
        checks++;
        if (s0 != sa || s1 != sb) begin
            errors++;
            $display("FAIL b2b sums: got %0d %0d want %0d %0d", s0, s1, sa, sb);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_max();
        test_ramp();
        test_stalls();
        test_reset_mid();
        test_single_beat();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
